ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: RAM data width.
REQ-003 SHALL have parameter WDT_CYCLES, default 255: halt-pending timeout in clk cycles, 8-bit counter.
REQ-004 SHALL have port clk  in  1  internal HFOSC clock; the only clock.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port load_done  in  1  flash image load complete.
REQ-007 SHALL have ports fl_addr/fl_wdata/fl_cs/fl_we  in  ADDR_W/DATA_W/1/1  flash loader RAM request.
REQ-008 SHALL have ports cpu_addr/cpu_wdata/cpu_sel/cpu_we  in  ADDR_W/DATA_W/1/1  decoded CPU bus access.
REQ-009 SHALL have port phi2  in  1  asynchronous CPU phase-2 clock.
REQ-010 SHALL have port dg_halt_req  in  1  diagnostics requests CPU halt.
REQ-011 SHALL have ports dg_addr/dg_wdata/dg_cs/dg_we  in  ADDR_W/DATA_W/1/1  diagnostics RAM request.
REQ-012 SHALL have ports ram_addr/ram_wdata/ram_cs/ram_we  out  ADDR_W/DATA_W/1/1  shared SRAM port.
REQ-013 SHALL have ports rdy/halted/dg_gnt/wdt_flag  out  1 each  CPU ready, halt acknowledged, diag grant, timeout seen.

Function
REQ-014 SHALL implement states LOAD, RUN, HALT_PEND, HALTED in one state register.
REQ-015 SHALL sync phi2 through two flops, then detect a falling edge one cycle later (3-cycle detection latency).
REQ-016 LOAD: ram_* SHALL mirror fl_*; rdy=0, halted=0, dg_gnt=0.
REQ-017 LOAD -> RUN SHALL occur on the first clk edge with load_done=1.
REQ-018 RUN: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_cs=cpu_sel, ram_we=cpu_we&cpu_sel; rdy=1.
REQ-019 RUN with dg_halt_req=1 SHALL go to HALT_PEND; rdy SHALL be 0 from the next cycle.
REQ-020 HALT_PEND: the CPU SHALL keep the port so its in-flight cycle completes; rdy=0.
REQ-021 HALT_PEND -> HALTED SHALL occur on the detected phi2 falling edge; halted=1 from that edge.
REQ-022 HALTED: ram_* SHALL mirror dg_*; dg_gnt=1; cpu_sel SHALL be ignored.
REQ-023 HALT_PEND or HALTED with dg_halt_req=0 SHALL go to RUN next edge; rdy=1 and halted=0 in the same cycle.
REQ-024 load_done=0 in any non-LOAD state SHALL go to LOAD next edge and SHALL override dg_halt_req.
REQ-025 dg_halt_req SHALL be ignored in LOAD; a request held through LOAD SHALL be honoured from RUN.
REQ-026 ram_* muxing SHALL be combinational from the state register, adding zero latency.

Reset
REQ-027 rst=0 SHALL asynchronously force LOAD, clear the sync flops, the counter and wdt_flag.
REQ-028 Outputs during reset: rdy=0, halted=0, dg_gnt=0, wdt_flag=0, ram_* = fl_*.
REQ-029 Reset release mid-load SHALL restart in LOAD; the flash loader SHALL re-issue its accesses.

Configuration
REQ-030 Macro ARB_HALT_WDT_EN defined: HALT_PEND SHALL count clk cycles; on reaching WDT_CYCLES with no phi2 falling edge it SHALL enter HALTED and set wdt_flag, sticky until reset.
REQ-031 The counter SHALL clear on entry to HALT_PEND and SHALL saturate, not wrap.
REQ-032 Macro undefined: HALT_PEND SHALL wait indefinitely, wdt_flag SHALL be tied 0 and no counter SHALL exist.

Verification
REQ-033 Reset, fl_cs=1, fl_addr=16'h1234, load_done=0 -> ram_addr=16'h1234, ram_cs=1, rdy=0.
REQ-034 load_done 0->1, cpu_sel=1, cpu_we=1, cpu_addr=16'h8000 -> next cycle ram_addr=16'h8000, ram_we=1, rdy=1.
REQ-035 RUN with phi2 toggling, dg_halt_req=1 -> rdy=0 next cycle; halted=1 within 3 clk of the phi2 fall; dg_addr=16'h0400 appears on ram_addr.
REQ-036 HALTED, dg_halt_req=0 -> next cycle rdy=1, halted=0, ram_addr=cpu_addr.
REQ-037 ARB_HALT_WDT_EN, phi2 held 1, dg_halt_req=1 -> halted=1 and wdt_flag=1 after 255 cycles; without the macro, halted stays 0 for 1000 cycles.
REQ-038 HALTED, load_done 1->0 -> LOAD next edge; rdy=0, halted=0, ram_* = fl_*.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shared SRAM port arbiter. The port goes to the flash loader, then the CPU, then optionally to diagnostics once the CPU halts.
// Optional feature: define ARB_HALT_WDT_EN to bound the halt-pending wait with a watchdog that sets wdt_flag.
module ram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WDT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] fl_addr,
  input  logic [DATA_W-1:0] fl_wdata,
  input  logic              fl_cs,
  input  logic              fl_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic              phi2,
  input  logic              dg_halt_req,
  input  logic [ADDR_W-1:0] dg_addr,
  input  logic [DATA_W-1:0] dg_wdata,
  input  logic              dg_cs,
  input  logic              dg_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              rdy,
  output logic              halted,
  output logic              dg_gnt,
  output logic              wdt_flag
);

  localparam logic [1:0] ST_LOAD      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_HALT_PEND = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] phi2_q, phi2_d;
  logic       phi2_fall;
  logic       wdt_timeout;

  // phi2_q[0..1] synchronise the async CPU clock; phi2_q[2] is one cycle older for edge detection.
  assign phi2_d    = {phi2_q[1:0], phi2};
  assign phi2_fall = phi2_q[2] & ~phi2_q[1];

`ifdef ARB_HALT_WDT_EN
  localparam logic [7:0] WDT_LAST = 8'(WDT_CYCLES - 1);

  logic [7:0] wdt_cnt_q, wdt_cnt_d;
  logic       wdt_flag_q, wdt_flag_d;

  // Counter idles at zero outside HALT_PEND so it starts cleared on every entry.
  always_comb begin
    wdt_cnt_d = '0;
    if (state_q == ST_HALT_PEND) begin
      wdt_cnt_d = (wdt_cnt_q == 8'hFF) ? wdt_cnt_q : wdt_cnt_q + 8'd1;
    end
    wdt_timeout = (state_q == ST_HALT_PEND) && (wdt_cnt_q >= WDT_LAST);
    wdt_flag_d  = wdt_flag_q |
                  (wdt_timeout && load_done && dg_halt_req && !phi2_fall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_q  <= '0;
      wdt_flag_q <= 1'b0;
    end else begin
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_flag_q <= wdt_flag_d;
    end
  end

  assign wdt_flag = wdt_flag_q;
`else
  assign wdt_timeout = 1'b0;
  assign wdt_flag    = 1'b0;
`endif

  // Loss of load_done wins over everything else in every non-LOAD state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!load_done)       state_d = ST_LOAD;
        else if (dg_halt_req) state_d = ST_HALT_PEND;
      end
      ST_HALT_PEND: begin
        if (!load_done)                    state_d = ST_LOAD;
        else if (!dg_halt_req)             state_d = ST_RUN;
        else if (phi2_fall || wdt_timeout) state_d = ST_HALTED;
      end
      default: begin
        if (!load_done)        state_d = ST_LOAD;
        else if (!dg_halt_req) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      phi2_q  <= '0;
    end else begin
      state_q <= state_d;
      phi2_q  <= phi2_d;
    end
  end

  // The CPU keeps the port during HALT_PEND so its in-flight bus cycle completes.
  always_comb begin
    ram_addr  = fl_addr;
    ram_wdata = fl_wdata;
    ram_cs    = fl_cs;
    ram_we    = fl_we;
    rdy       = 1'b0;
    halted    = 1'b0;
    dg_gnt    = 1'b0;
    case (state_q)
      ST_RUN, ST_HALT_PEND: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_cs    = cpu_sel;
        ram_we    = cpu_we & cpu_sel;
        rdy       = (state_q == ST_RUN);
      end
      ST_HALTED: begin
        ram_addr  = dg_addr;
        ram_wdata = dg_wdata;
        ram_cs    = dg_cs;
        ram_we    = dg_we;
        halted    = 1'b1;
        dg_gnt    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_ram_port_arbiter;

  localparam int WDT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_done = 1'b0;
  logic [15:0] fl_addr = '0, cpu_addr = '0, dg_addr = '0;
  logic [7:0]  fl_wdata = '0, cpu_wdata = '0, dg_wdata = '0;
  logic        fl_cs = 1'b0, fl_we = 1'b0, cpu_sel = 1'b0, cpu_we = 1'b0;
  logic        dg_cs = 1'b0, dg_we = 1'b0;
  logic        phi2 = 1'b1;
  logic        dg_halt_req = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_cs, ram_we, rdy, halted, dg_gnt, wdt_flag;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .load_done(load_done),
    .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_cs(fl_cs), .fl_we(fl_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .phi2(phi2), .dg_halt_req(dg_halt_req),
    .dg_addr(dg_addr), .dg_wdata(dg_wdata), .dg_cs(dg_cs), .dg_we(dg_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
    .rdy(rdy), .halted(halted), .dg_gnt(dg_gnt), .wdt_flag(wdt_flag)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the port, phi2 samples taken at clock edges, cycles spent waiting for a halt.
  typedef enum {M_LOAD, M_RUN, M_PEND, M_HALTED} mode_e;
  mode_e    m_mode;
  int       m_pend;
  bit       m_wdt;
  bit [2:0] m_hist;   // [2]=phi2 three edges ago, [1]=two edges ago, [0]=last edge
  bit       m_fall;

  assign m_fall = m_hist[2] && !m_hist[1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= M_LOAD;
      m_pend <= 0;
      m_wdt  <= 1'b0;
      m_hist <= 3'b000;
    end else begin
      m_hist <= {m_hist[1:0], phi2};
      case (m_mode)
        M_LOAD: if (load_done) m_mode <= M_RUN;
        M_RUN: begin
          if (!load_done) m_mode <= M_LOAD;
          else if (dg_halt_req) begin
            m_mode <= M_PEND;
            m_pend <= 0;
          end
        end
        M_PEND: begin
          if (!load_done) m_mode <= M_LOAD;
          else if (!dg_halt_req) m_mode <= M_RUN;
          else if (m_fall) m_mode <= M_HALTED;
          else begin
`ifdef ARB_HALT_WDT_EN
            if (m_pend + 1 >= WDT) begin
              m_mode <= M_HALTED;
              m_wdt  <= 1'b1;
            end
`endif
            m_pend <= m_pend + 1;
          end
        end
        M_HALTED: begin
          if (!load_done) m_mode <= M_LOAD;
          else if (!dg_halt_req) m_mode <= M_RUN;
        end
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    load_done = 1'b0; fl_cs = 1'b1; fl_we = 1'b0; fl_addr = 16'h1234;
    rst = 1'b0;
    #1;
    checks++; if (ram_addr !== 16'h1234) begin errors++; $display("FAIL reset_ram_addr: got %h expected 1234", ram_addr); end
    checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL reset_ram_cs: got %b expected 1", ram_cs); end
    checks++; if ({rdy, halted, dg_gnt, wdt_flag} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rdy, halted, dg_gnt, wdt_flag}); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0 || ram_addr !== 16'h1234) begin errors++; $display("FAIL reset_stay_load: rdy=%b addr=%h expected rdy=0 addr=1234", rdy, ram_addr); end
  endtask

  task automatic test_load_to_run();
    @(negedge clk);
    load_done = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h5C;
    #1;
    checks++; if (rdy !== 1'b0 || ram_addr !== 16'h1234) begin errors++; $display("FAIL load_before_edge: rdy=%b addr=%h expected rdy=0 addr=1234", rdy, ram_addr); end
    @(posedge clk); #1;
    checks++; if (ram_addr !== 16'h8000) begin errors++; $display("FAIL run_ram_addr: got %h expected 8000", ram_addr); end
    checks++; if (ram_we !== 1'b1 || ram_wdata !== 8'h5C) begin errors++; $display("FAIL run_ram_we: we=%b wdata=%h expected we=1 wdata=5c", ram_we, ram_wdata); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL run_rdy: got %b expected 1", rdy); end
    @(negedge clk);
    cpu_sel = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL run_we_gated: we=%b cs=%b expected 0 0", ram_we, ram_cs); end
  endtask

  task automatic test_halt_phi2();
    int n;
    @(negedge clk);
    phi2 = 1'b1; dg_addr = 16'h0400; dg_cs = 1'b1; dg_we = 1'b0;
    cpu_addr = 16'h2222; cpu_sel = 1'b1; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    dg_halt_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL pend_flags: rdy=%b halted=%b expected 0 0", rdy, halted); end
    checks++; if (ram_addr !== 16'h2222) begin errors++; $display("FAIL pend_cpu_owns: got %h expected 2222", ram_addr); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL pend_no_fall: halted=%b expected 0", halted); end
    @(negedge clk);
    phi2 = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL phi2_latency: got %0d edges expected 3", n); end
    checks++; if (ram_addr !== 16'h0400 || dg_gnt !== 1'b1) begin errors++; $display("FAIL halted_dg_port: addr=%h gnt=%b expected 0400 1", ram_addr, dg_gnt); end
    @(negedge clk);
    cpu_sel = 1'b1; cpu_we = 1'b1; dg_cs = 1'b0; dg_we = 1'b0;
    #1;
    checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL halted_cpu_ignored: cs=%b we=%b expected 0 0", ram_cs, ram_we); end
  endtask

  task automatic test_release();
    @(negedge clk);
    dg_halt_req = 1'b0; cpu_addr = 16'h3456;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b1 || halted !== 1'b0 || dg_gnt !== 1'b0) begin errors++; $display("FAIL release_flags: rdy=%b halted=%b gnt=%b expected 1 0 0", rdy, halted, dg_gnt); end
    checks++; if (ram_addr !== 16'h3456) begin errors++; $display("FAIL release_addr: got %h expected 3456", ram_addr); end
  endtask

  task automatic test_load_abort();
    int  n;
    bit  bad;
    @(negedge clk);
    phi2 = 1'b1; dg_halt_req = 1'b1;
    repeat (3) @(negedge clk);
    phi2 = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL abort_reach_halted: halted=%b expected 1", halted); end
    @(negedge clk);
    load_done = 1'b0; fl_addr = 16'h5A5A; fl_wdata = 8'hA5; fl_cs = 1'b1; fl_we = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0 || halted !== 1'b0 || dg_gnt !== 1'b0) begin errors++; $display("FAIL abort_flags: rdy=%b halted=%b gnt=%b expected 0 0 0", rdy, halted, dg_gnt); end
    checks++; if (ram_addr !== 16'h5A5A || ram_we !== 1'b1 || ram_wdata !== 8'hA5) begin errors++; $display("FAIL abort_fl_port: addr=%h we=%b wdata=%h expected 5a5a 1 a5", ram_addr, ram_we, ram_wdata); end
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy !== 1'b0 || halted !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL load_ignores_halt: rdy=%b halted=%b expected 0 0", rdy, halted); end
    @(negedge clk);
    load_done = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL held_req_run: rdy=%b expected 1", rdy); end
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL held_req_pend: rdy=%b expected 0", rdy); end
    @(negedge clk);
    dg_halt_req = 1'b0; phi2 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_watchdog();
    int n;
    @(negedge clk);
    phi2 = 1'b1; dg_halt_req = 1'b0; load_done = 1'b1;
    repeat (4) @(negedge clk);
    dg_halt_req = 1'b1;
    n = 0;
`ifdef ARB_HALT_WDT_EN
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (halted === 1'b1) break;
      if (rdy === 1'b0) n++;
    end
    checks++; if (halted !== 1'b1 || n != WDT) begin errors++; $display("FAIL wdt_timeout: halted=%b after %0d pending cycles expected 1 after %0d", halted, n, WDT); end
    checks++; if (wdt_flag !== 1'b1) begin errors++; $display("FAIL wdt_flag_set: got %b expected 1", wdt_flag); end
    @(negedge clk);
    dg_halt_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (wdt_flag !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL wdt_flag_sticky: flag=%b rdy=%b expected 1 1", wdt_flag, rdy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (wdt_flag !== 1'b0) begin errors++; $display("FAIL wdt_flag_reset: got %b expected 0", wdt_flag); end
    @(negedge clk);
    rst = 1'b1;
`else
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (halted === 1'b1 || wdt_flag !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL no_wdt_wait: %0d cycles with halted or wdt_flag set, expected 0", n); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL no_wdt_pending: rdy=%b expected 0", rdy); end
    @(negedge clk);
    dg_halt_req = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_cs, e_we, e_rdy, e_halted, e_gnt;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 63) == 0) load_done = ~load_done;
      else if (!load_done && $urandom_range(0, 3) == 0) load_done = 1'b1;
      if ($urandom_range(0, 15) == 0) dg_halt_req = ~dg_halt_req;
      if ($urandom_range(0, 5) == 0) phi2 = ~phi2;
      fl_addr  = 16'($urandom); fl_wdata  = 8'($urandom); fl_cs  = 1'($urandom); fl_we  = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_sel = 1'($urandom); cpu_we = 1'($urandom);
      dg_addr  = 16'($urandom); dg_wdata  = 8'($urandom); dg_cs  = 1'($urandom); dg_we  = 1'($urandom);
      @(posedge clk); #1;
      e_rdy = 1'b0; e_halted = 1'b0; e_gnt = 1'b0;
      case (m_mode)
        M_LOAD:   begin e_addr = fl_addr;  e_wdata = fl_wdata;  e_cs = fl_cs;   e_we = fl_we; end
        M_RUN:    begin e_addr = cpu_addr; e_wdata = cpu_wdata; e_cs = cpu_sel; e_we = cpu_we & cpu_sel; e_rdy = 1'b1; end
        M_PEND:   begin e_addr = cpu_addr; e_wdata = cpu_wdata; e_cs = cpu_sel; e_we = cpu_we & cpu_sel; end
        default:  begin e_addr = dg_addr;  e_wdata = dg_wdata;  e_cs = dg_cs;   e_we = dg_we; e_halted = 1'b1; e_gnt = 1'b1; end
      endcase
      checks++;
      if ({ram_addr, ram_wdata, ram_cs, ram_we} !== {e_addr, e_wdata, e_cs, e_we}) begin
        errors++;
        $display("FAIL rand_port cycle %0d: got %h/%h/%b/%b expected %h/%h/%b/%b", i, ram_addr, ram_wdata, ram_cs, ram_we, e_addr, e_wdata, e_cs, e_we);
      end
      checks++;
      if ({rdy, halted, dg_gnt, wdt_flag} !== {e_rdy, e_halted, e_gnt, m_wdt}) begin
        errors++;
        $display("FAIL rand_flags cycle %0d: got %b expected %b", i, {rdy, halted, dg_gnt, wdt_flag}, {e_rdy, e_halted, e_gnt, m_wdt});
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_to_run();
    test_halt_phi2();
    test_release();
    test_load_abort();
    test_watchdog();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
